// File: rtl/dac_shift_buffer_if.sv
// Bundle for dac_shift_buffer: word stream in/out, shift-update handshake, FSM debug view.
// in_valid qualifies in_word each cycle, and there is no ready because the buffer always accepts; out_valid qualifies out_word.
interface dac_shift_buffer_if #(
    parameter int SAMPLE_W   = 16,
    parameter int SAMPLES    = 16,
    parameter int HIST_WORDS = 1,
    parameter int SHIFT_W    = $clog2(HIST_WORDS * SAMPLES)
);
    localparam int WORD_W = SAMPLE_W * SAMPLES;

    logic               in_valid;
    logic [WORD_W-1:0]  in_word;
    logic               shift_wr;
    logic [SHIFT_W-1:0] shift_in;
    logic               shift_busy;
    logic               shift_ack;
    logic               shift_sat;
    logic [SHIFT_W-1:0] cur_shift;
    logic               out_valid;
    logic [WORD_W-1:0]  out_word;
    logic               run_state;

    modport master (
        output in_valid, in_word, shift_wr, shift_in,
        input  shift_busy, shift_ack, shift_sat, cur_shift, out_valid, out_word, run_state
    );

    modport slave (
        input  in_valid, in_word, shift_wr, shift_in,
        output shift_busy, shift_ack, shift_sat, cur_shift, out_valid, out_word, run_state
    );
endinterface

// File: rtl/dac_shift_buffer.sv
// Sample-granular delay buffer for DAC word streams with a glitch-free shift-update handshake.
// Optional second output register stage: define DAC_SHIFT_OUT_REG_EN.
module dac_shift_buffer #(
    parameter int SAMPLE_W   = 16,
    parameter int SAMPLES    = 16,
    parameter int HIST_WORDS = 1,
    parameter int SHIFT_W    = $clog2(HIST_WORDS * SAMPLES)
) (
    input logic             clk,
    input logic             rst,
    dac_shift_buffer_if.slave bus
);
    localparam int WORD_W       = SAMPLE_W * SAMPLES;
    localparam int HIST_SAMPLES = HIST_WORDS * SAMPLES;
    localparam int MAX_SHIFT    = HIST_SAMPLES - 1;
    localparam int C_W          = (HIST_WORDS + 1) * WORD_W;
    localparam int BASE_W       = $clog2(C_W);
    localparam int FILL_W       = $clog2(HIST_WORDS + 1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [WORD_W-1:0]  hist_q [HIST_WORDS];
    logic [C_W-1:0]     c_vec;
    logic [SHIFT_W-1:0] cur_q, pend_q, eff_shift, shift_clamped;
    logic               busy_q, ack_q, sat_q, over_range;
    logic [BASE_W-1:0]  win_base;
    logic [WORD_W-1:0]  s1_word;
    logic               s1_valid;

    // Fill state machine: FILL until HIST_WORDS words have primed the history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (state_q == FILL && bus.in_valid) begin
            if (fill_q == FILL_W'(HIST_WORDS - 1)) begin
                state_d = RUN;
                fill_d  = FILL_W'(HIST_WORDS);
            end else begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // C = {in_word, H[0], ..., H[HIST_WORDS-1]}, oldest history word in the LSBs.
    always_comb begin
        c_vec = '0;
        c_vec[C_W-1 -: WORD_W] = bus.in_word;
        for (int h = 0; h < HIST_WORDS; h++) begin
            c_vec[(HIST_WORDS - h) * WORD_W - 1 -: WORD_W] = hist_q[h];
        end
    end

    // A pending shift takes effect on the very word that applies it.
    always_comb begin
        eff_shift     = busy_q ? pend_q : cur_q;
        win_base      = BASE_W'((HIST_SAMPLES - int'(eff_shift)) * SAMPLE_W);
        over_range    = ({1'b0, bus.shift_in} > (SHIFT_W + 1)'(MAX_SHIFT));
        shift_clamped = over_range ? SHIFT_W'(MAX_SHIFT) : bus.shift_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int h = 0; h < HIST_WORDS; h++) begin
                hist_q[h] <= '0;
            end
            s1_word  <= '0;
            s1_valid <= 1'b0;
            cur_q    <= '0;
            pend_q   <= '0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            ack_q    <= 1'b0;
            s1_valid <= bus.in_valid && (state_q == RUN);
            if (bus.in_valid) begin
                hist_q[0] <= bus.in_word;
                for (int h = 1; h < HIST_WORDS; h++) begin
                    hist_q[h] <= hist_q[h-1];
                end
                s1_word <= c_vec[win_base +: WORD_W];
                if (busy_q) begin
                    cur_q  <= pend_q;
                    busy_q <= 1'b0;
                    ack_q  <= 1'b1;
                end
            end
            // A new request wins over the clear above and waits for the next accepted word.
            if (bus.shift_wr) begin
                pend_q <= shift_clamped;
                busy_q <= 1'b1;
                if (over_range) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

`ifdef DAC_SHIFT_OUT_REG_EN
    logic [WORD_W-1:0] s2_word;
    logic              s2_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_word  <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_word  <= s1_word;
            s2_valid <= s1_valid;
        end
    end

    assign bus.out_word  = s2_word;
    assign bus.out_valid = s2_valid;
`else
    assign bus.out_word  = s1_word;
    assign bus.out_valid = s1_valid;
`endif

    assign bus.shift_busy = busy_q;
    assign bus.shift_ack  = ack_q;
    assign bus.shift_sat  = sat_q;
    assign bus.cur_shift  = cur_q;
    assign bus.run_state  = (state_q == RUN);
endmodule

// File: tb/tb_dac_shift_buffer.sv
// Directed plus randomized bench for dac_shift_buffer against a sample-stream reference model.
// Shift fields are widened to 5 bits so that out-of-range requests (e.g. 20) can be driven.
module tb_dac_shift_buffer;
    localparam int SW   = 16;
    localparam int NS   = 16;
    localparam int HW   = 1;
    localparam int SHW  = 5;
    localparam int WW   = SW * NS;
    localparam int MAXS = HW * NS - 1;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    dac_shift_buffer_if #(.SAMPLE_W(SW), .SAMPLES(NS), .HIST_WORDS(HW), .SHIFT_W(SHW)) bus ();

    dac_shift_buffer #(.SAMPLE_W(SW), .SAMPLES(NS), .HIST_WORDS(HW), .SHIFT_W(SHW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: every accepted sample in arrival order, plus handshake state.
    logic [SW-1:0] samp_q[$];
    int            nacc;
    int            m_cur, m_pend;
    bit            m_busy, m_ack, m_sat;
    bit            m_valid1, m_valid2;
    logic [WW-1:0] m_word1, m_word2;

    function automatic logic [WW-1:0] mk(input int k);
        logic [WW-1:0] r;
        for (int i = 0; i < NS; i++) r[i*SW +: SW] = SW'(16 * k + i);
        return r;
    endfunction

    function automatic logic [WW-1:0] rnd_word();
        logic [WW-1:0] r;
        for (int i = 0; i < NS; i++) r[i*SW +: SW] = SW'($urandom);
        return r;
    endfunction

    // Output word = input stream delayed by s samples; samples before the stream start are zero.
    function automatic logic [WW-1:0] window(input int widx, input int s);
        logic [WW-1:0] r;
        int idx;
        r = '0;
        for (int j = 0; j < NS; j++) begin
            idx = widx * NS + j - s;
            if (idx >= 0) r[j*SW +: SW] = samp_q[idx];
        end
        return r;
    endfunction

    task automatic model_update(input bit r, input bit iv, input logic [WW-1:0] w,
                                input bit wr, input int sh);
        int s;
        if (!r) begin
            samp_q.delete();
            nacc = 0; m_cur = 0; m_pend = 0;
            m_busy = 0; m_ack = 0; m_sat = 0;
            m_valid1 = 0; m_valid2 = 0; m_word1 = '0; m_word2 = '0;
        end else begin
            m_valid2 = m_valid1;
            m_word2  = m_word1;
            m_ack    = 0;
            if (iv) begin
                s = m_busy ? m_pend : m_cur;
                if (m_busy) begin
                    m_cur = m_pend; m_busy = 0; m_ack = 1;
                end
                for (int i = 0; i < NS; i++) samp_q.push_back(w[i*SW +: SW]);
                nacc++;
                m_valid1 = (nacc - 1) >= HW;
                m_word1  = window(nacc - 1, s);
            end else begin
                m_valid1 = 0;
            end
            if (wr) begin
                m_pend = (sh > MAXS) ? MAXS : sh;
                m_busy = 1;
                if (sh > MAXS) m_sat = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit iv, input logic [WW-1:0] w,
                        input bit wr, input int sh);
        rst          = r;
        bus.in_valid = iv;
        bus.in_word  = w;
        bus.shift_wr = wr;
        bus.shift_in = SHW'(sh);
        @(posedge clk);
        #1;
        model_update(r, iv, w, wr, sh);
`ifdef DAC_SHIFT_OUT_REG_EN
        chk("out_valid", WW'(bus.out_valid), WW'(m_valid2));
        chk("out_word", bus.out_word, m_word2);
`else
        chk("out_valid", WW'(bus.out_valid), WW'(m_valid1));
        chk("out_word", bus.out_word, m_word1);
`endif
        chk("shift_busy", WW'(bus.shift_busy), WW'(m_busy));
        chk("shift_ack", WW'(bus.shift_ack), WW'(m_ack));
        chk("shift_sat", WW'(bus.shift_sat), WW'(m_sat));
        chk("cur_shift", WW'(bus.cur_shift), WW'(m_cur));
        chk("run_state", WW'(bus.run_state), WW'(nacc >= HW));
    endtask

    task automatic idle();
        step(1, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 1, 9);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_word  = '0;
        bus.shift_wr = 1'b0;
        bus.shift_in = '0;

        // Reset values, then continuous words with shift 0 and a shift of 3 before word 2.
        do_reset();
        chk("rst_out_word", bus.out_word, '0);
        chk("rst_busy", WW'(bus.shift_busy), '0);
        step(1, 1, mk(0), 0, 0);
        step(1, 1, mk(1), 0, 0);
        step(1, 0, '0, 1, 3);
        step(1, 1, mk(2), 0, 0);
        idle();
        chk("w2_s0_shift3", WW'(bus.out_word[SW-1:0]), WW'(29));
        chk("w2_cur3", WW'(bus.cur_shift), WW'(3));
        step(1, 1, mk(3), 0, 0);
        for (int g = 0; g < 4; g++) idle();
        step(1, 1, mk(4), 0, 0);
        step(1, 1, mk(5), 0, 0);

        // Out-of-range request clamps to MAX_SHIFT and sets the sticky flag.
        do_reset();
        step(1, 1, mk(0), 0, 0);
        step(1, 1, mk(1), 0, 0);
        step(1, 1, mk(2), 0, 0);
        step(1, 0, '0, 1, 20);
        step(1, 1, mk(3), 0, 0);
        idle();
        chk("w3_s0_sat", WW'(bus.out_word[SW-1:0]), WW'(33));
        chk("clamp_cur15", WW'(bus.cur_shift), WW'(15));
        chk("sat_set", WW'(bus.shift_sat), WW'(1));
        step(1, 1, mk(4), 1, 2);
        step(1, 1, mk(5), 0, 0);

        // Request in the same cycle as a word applies to the following word.
        do_reset();
        step(1, 1, mk(0), 0, 0);
        step(1, 1, mk(1), 0, 0);
        step(1, 1, mk(2), 1, 5);
        chk("same_cycle_no_ack", WW'(bus.shift_ack), '0);
        step(1, 1, mk(3), 0, 0);
        chk("next_word_ack", WW'(bus.shift_ack), WW'(1));
        chk("next_word_cur5", WW'(bus.cur_shift), WW'(5));
        step(1, 1, mk(4), 1, 1);
        step(1, 0, '0, 1, 14);
        step(1, 1, mk(5), 0, 0);

        // Reset while a request is pending discards it.
        do_reset();
        step(1, 1, mk(0), 0, 0);
        step(1, 1, mk(1), 0, 0);
        step(1, 0, '0, 1, 7);
        step(0, 1, mk(2), 1, 2);
        chk("rst_busy_clear", WW'(bus.shift_busy), '0);
        step(1, 1, mk(0), 0, 0);
        idle();
        chk("post_rst_valid", WW'(bus.out_valid), '0);
        chk("post_rst_cur", WW'(bus.cur_shift), '0);

        // Randomized traffic with gaps, shift requests and occasional resets.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0, rnd_word(),
                 $urandom_range(0, 7) == 0, int'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dac_shift_buffer.md
# dac_shift_buffer

Parametrised sample-granular delay buffer for DAC word streams. It generalises the single-sample-shift output stage to configurable sample width, samples per word and history depth. It adds a valid-qualified input, a fill state machine and a glitch-free shift-update handshake. It sits between the pulse/sequence generator and the DAC AXI-stream port, one instance per DAC channel.

## Interface
Parameters:
- SAMPLE_W, 16: bits per DAC sample.
- SAMPLES, 16: samples per DAC word. Word width WORD_W = SAMPLE_W*SAMPLES.
- HIST_WORDS, 1: past words retained. Shift range is 0..MAX_SHIFT, where MAX_SHIFT = HIST_WORDS*SAMPLES-1.
- SHIFT_W, $clog2(HIST_WORDS*SAMPLES): width of shift fields.

Ports (reset is synchronous and active-low):
- clk, in, 1: sole clock.
- rst, in, 1: synchronous active-low reset.
- in_valid, in, 1: in_word is accepted this cycle.
- in_word, in, WORD_W: sample 0 in bits [SAMPLE_W-1:0]; sample 0 is earliest in time.
- shift_wr, in, 1: single-cycle request to load a new shift.
- shift_in, in, SHIFT_W: requested shift in samples.
- shift_busy, out, 1: a shift request is pending and not yet applied.
- shift_ack, out, 1: one-cycle pulse when the pending shift takes effect.
- shift_sat, out, 1: sticky flag; a request exceeded MAX_SHIFT and was clamped.
- cur_shift, out, SHIFT_W: shift currently applied.
- out_valid, out, 1: out_word holds valid data.
- out_word, out, WORD_W: delayed word.

## Operation
- History: HIST_WORDS registered words, H[0] newest. All words advance only when in_valid=1.
- Concatenation: C = {in_word, H[0], …, H[HIST_WORDS-1]}, with H[HIST_WORDS-1] in the LSBs. C holds (HIST_WORDS+1)*SAMPLES samples.
- Window selection: on an accepted word, out_word <= C[(HIST_WORDS*SAMPLES - s)*SAMPLE_W +: WORD_W], where s = cur_shift in effect for that word.
  - The output stream is the input stream delayed by s samples.
  - s=0 means out_word equals in_word.
- FSM:
  - FILL (reset state): counts accepted words in fill_cnt, range 0..HIST_WORDS. out_valid stays 0. Moves to RUN on the accepted word that brings fill_cnt to HIST_WORDS.
  - RUN: out_valid <= in_valid every cycle.
  - No path back to FILL except reset.
- Shift handshake:
  - shift_wr latches min(shift_in, MAX_SHIFT) into a pending register. shift_busy=1 from the next cycle onward.
  - If shift_in > MAX_SHIFT, shift_sat is set and stays set until reset.
  - The pending value is applied on the first accepted word after the shift_wr cycle. That word already uses the new shift.
  - In the cycle the pending value is applied: cur_shift updates, shift_busy clears and shift_ack pulses for one cycle. These happen together with that word's out_valid.
  - A shift_wr in the same cycle as in_valid does not affect that word; it applies to the next accepted word.
  - A shift_wr while busy overwrites the pending value; only one ack is issued.
  - Pending requests are applied in FILL as well as in RUN.
- in_valid gaps: history, out_word and cur_shift hold. out_valid=0.

## Timing
- Reset values: out_word=0, out_valid=0, shift_busy=0, shift_ack=0, shift_sat=0, cur_shift=0. History is zeroed and the FSM enters FILL.
- Latency: one cycle from accepted in_word to out_word/out_valid (two cycles with DAC_SHIFT_OUT_REG_EN).
- Full throughput: one word per clock, with in_valid held high indefinitely.
- Reset asserted mid-stream wins over all other inputs that cycle. A pending shift is discarded and the FSM restarts in FILL.
- shift_wr during reset is ignored.

## Configuration
- DAC_SHIFT_OUT_REG_EN:
  - Defined: adds a second register stage on out_word and out_valid for DAC timing closure. Latency is 2 cycles. shift_ack stays aligned with the first-stage apply cycle.
  - Undefined: single-stage output, latency 1.

## Test plan
All scenarios use SAMPLE_W=16, SAMPLES=16, HIST_WORDS=1, with word k sample i = 16k+i.
- Reset then continuous words k=0..3 with shift 0 -> out_valid is 0 for word 0 (FILL). Word k≥1 appears unchanged one cycle later; out_word sample j = 16k+j.
- shift_wr with shift_in=3 before word 2 -> shift_busy=1, then shift_ack pulses with word 2's output. Output sample j = 32+j-3, so sample 0 = 29.
- shift_wr with shift_in=20 -> cur_shift=15 and shift_sat=1, held until reset. Output of word 3 has sample 0 = 33.
- shift_wr in the same cycle as word 2's in_valid with shift_in=5 -> word 2 uses the old shift. Word 3 uses 5 and shift_ack fires then.
- in_valid low for 4 cycles mid-stream -> out_valid=0 and out_word holds. The resumed stream continues sample-continuous across the gap.
- Assert rst low while shift_busy=1 -> all outputs return to reset values and the pending shift is never acked. The first word after reset yields out_valid=0.
